// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - Receive-side 8-channel TDM demultiplexer with frame-sync lock
//
// Rebuilds eight parallel channel bits from a serial slot stream. The block
// waits in HUNT for a sync marker, then tracks the slot index in LOCK. It
// commits each complete frame to i0..i7 in a single edge.
//
// Optional feature macro: TDM_DEMUX8_PARITY_EN adds a ninth, even-parity slot.
// Frames that fail the parity check are dropped and par_err pulses.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           slot strobe; din/sync are sampled only when en=1
//   din, sync    serial channel bit and frame marker (high with slot 0)
//   i0..i7       channel outputs from the last good frame
//   s            slot index expected for the next accepted bit
//   locked       high while in LOCK
//   frame_valid  one-cycle pulse when i0..i7 update
//   sync_err     one-cycle pulse on a misplaced sync
//   par_err      one-cycle pulse on a parity mismatch (0 without parity)

module tdm_demux8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic       i0,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       i4,
    output logic       i5,
    output logic       i6,
    output logic       i7,
    output logic [3:0] s,
    output logic       locked,
    output logic       frame_valid,
    output logic       sync_err,
    output logic       par_err
);

    typedef enum logic {HUNT, LOCK} state_t;

`ifdef TDM_DEMUX8_PARITY_EN
    localparam logic [3:0] LAST_SLOT = 4'd8;
`else
    localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

    state_t     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] out_q, out_d;
    logic       fv_q, fv_d;
    logic       se_q, se_d;
`ifdef TDM_DEMUX8_PARITY_EN
    logic       pe_q, pe_d;
`endif

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
        pe_d     = 1'b0;
`endif
        if (en) begin
            if (state_q == HUNT) begin
                // Everything before the first sync is discarded.
                if (sync) begin
                    shadow_d[0] = din;
                    s_d         = 4'd1;
                    state_d     = LOCK;
                end
            end else if (sync && (s_q != 4'd0)) begin
                // Misplaced sync restarts the frame; it also overrides a
                // last-slot commit, so no output update on this edge.
                se_d        = 1'b1;
                shadow_d[0] = din;
                s_d         = 4'd1;
            end else if (s_q == LAST_SLOT) begin
`ifdef TDM_DEMUX8_PARITY_EN
                // Even parity across 8 data bits plus the parity slot.
                if (din == ^shadow_q) begin
                    out_d = shadow_q;
                    fv_d  = 1'b1;
                end else begin
                    pe_d  = 1'b1;
                end
`else
                shadow_d[7] = din;
                out_d       = {din, shadow_q[6:0]};
                fv_d        = 1'b1;
`endif
                s_d = 4'd0;
            end else begin
                shadow_d[s_q[2:0]] = din;
                s_d                = s_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            s_q      <= 4'd0;
            shadow_q <= 8'd0;
            out_q    <= 8'd0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
            pe_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
`ifdef TDM_DEMUX8_PARITY_EN
            pe_q     <= pe_d;
`endif
        end
    end

    assign {i7, i6, i5, i4, i3, i2, i1, i0} = out_q;
    assign s           = s_q;
    assign locked      = (state_q == LOCK);
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
`ifdef TDM_DEMUX8_PARITY_EN
    assign par_err     = pe_q;
`else
    assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - Self-checking bench for tdm_demux8 (frame-queue model plus directed checks)

module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic       i0, i1, i2, i3, i4, i5, i6, i7;
    logic [3:0] s;
    logic       locked, frame_valid, sync_err, par_err;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

`ifdef TDM_DEMUX8_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    tdm_demux8 dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
        .s(s), .locked(locked), .frame_valid(frame_valid),
        .sync_err(sync_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    // Model: the bits received so far in the current frame form a queue;
    // its length is the slot index, and a full queue is a frame.
    bit m_locked = 1'b0;
    bit m_frame[$];
    bit [7:0] m_out = 8'd0;
    bit m_fv = 1'b0, m_se = 1'b0, m_pe = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 1'b0;
            m_frame.delete();
            m_out = 8'd0;
            m_fv = 1'b0; m_se = 1'b0; m_pe = 1'b0;
        end else begin
            m_fv = 1'b0; m_se = 1'b0; m_pe = 1'b0;
            if (en) begin
                if (!m_locked) begin
                    if (sync) begin
                        m_locked = 1'b1;
                        m_frame.delete();
                        m_frame.push_back(din);
                    end
                end else if (sync && m_frame.size() != 0) begin
                    m_se = 1'b1;
                    m_frame.delete();
                    m_frame.push_back(din);
                end else begin
                    m_frame.push_back(din);
                    if (m_frame.size() == FRAME_LEN) begin
                        int ones;
                        ones = 0;
                        foreach (m_frame[k]) ones += int'(m_frame[k]);
                        if (FRAME_LEN == 8 || (ones % 2) == 0) begin
                            for (int k = 0; k < 8; k++) m_out[k] = m_frame[k];
                            m_fv = 1'b1;
                        end else begin
                            m_pe = 1'b1;
                        end
                        m_frame.delete();
                    end
                end
            end
        end
    end

    // Single every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [15:0] act, exp_v;
            act   = {i7, i6, i5, i4, i3, i2, i1, i0, s, locked, frame_valid, sync_err, par_err};
            exp_v = {m_out, 4'(m_frame.size()), m_locked, m_fv, m_se, m_pe};
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp_v);
            end
        end
    end

    task automatic pin(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic slot(input logic e, input logic sy, input logic d);
        @(negedge clk);
        en = e; sync = sy; din = d;
    endtask

    // Slots first..7 of frame b; optional 3-cycle en gap before slot gap_at;
    // parity slot appended in parity builds (flip=1 makes it wrong).
    task automatic send_frame(input logic [7:0] b, input logic sy0, input int first,
                              input int gap_at, input logic flip);
        for (int k = first; k < 8; k++) begin
            if (k == gap_at) repeat (3) slot(1'b0, 1'b0, 1'b0);
            slot(1'b1, (k == 0) ? sy0 : 1'b0, b[k]);
        end
`ifdef TDM_DEMUX8_PARITY_EN
        slot(1'b1, 1'b0, (^b) ^ flip);
`endif
    endtask

    function automatic logic [7:0] outs();
        return {i7, i6, i5, i4, i3, i2, i1, i0};
    endfunction

    initial begin
        int t0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        pin("reset_outs", {outs(), s, locked, frame_valid, sync_err, par_err}, 16'h0000);

        // Lock on sync, frame 1,1,1,1,0,0,0,0
        send_frame(8'h0F, 1'b1, 0, -1, 1'b0);
        @(posedge clk); #1;
        pin("lock_outs", outs(), 8'h0F);
        pin("lock_s", s, 0);
        pin("lock_locked", locked, 1);
        pin("lock_fv", frame_valid, 1);

        // Flywheel: no sync, frame 1,0,1,0,0,0,0,1
        send_frame(8'h85, 1'b0, 0, -1, 1'b0);
        @(posedge clk); #1;
        pin("fly_outs", outs(), 8'h85);
        pin("fly_fv", frame_valid, 1);

        // Misplaced sync at s=5
        for (int k = 0; k < 5; k++) slot(1'b1, 1'b0, 1'b0);
        slot(1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        pin("msync_err", sync_err, 1);
        pin("msync_s", s, 1);
        pin("msync_outs", outs(), 8'h85);
        send_frame(8'hC3, 1'b0, 1, -1, 1'b0);
        @(posedge clk); #1;
        pin("msync_commit", {outs(), 7'd0, frame_valid}, {8'hC3, 7'd0, 1'b1});

        // en gap of 3 cycles between slots 3 and 4
        slot(1'b0, 1'b0, 1'b0);
        t0 = $time;
        send_frame(8'h0F, 1'b0, 0, 4, 1'b0);
        @(posedge clk); #1;
        pin("gap_outs", outs(), 8'h0F);
        pin("gap_fv", frame_valid, 1);
        pin("gap_edges", 16'(($time - t0) / 10), 16'(FRAME_LEN + 3));

        // Reset asserted at s=4
        for (int k = 0; k < 4; k++) slot(1'b1, 1'b0, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        pin("rst_mid", {outs(), s, locked, frame_valid, sync_err, par_err}, 16'h0000);
        slot(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) slot(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        pin("hunt_ignore", {s, 3'd0, locked}, 8'h00);
        send_frame(8'h5A, 1'b1, 0, -1, 1'b0);
        @(posedge clk); #1;
        pin("relock_outs", outs(), 8'h5A);

`ifdef TDM_DEMUX8_PARITY_EN
        send_frame(8'h0F, 1'b0, 0, -1, 1'b1);
        @(posedge clk); #1;
        pin("par_err", {par_err, frame_valid}, 2'b10);
        pin("par_hold", outs(), 8'h5A);
        send_frame(8'h0F, 1'b0, 0, -1, 1'b0);
        @(posedge clk); #1;
        pin("par_ok", {outs(), 6'd0, par_err, frame_valid}, {8'h0F, 8'h01});
`else
        pin("par_tied", par_err, 0);
`endif

        slot(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Receive-side time-division demultiplexer: takes the serial stream produced by cycling an 8:1 mux select (one channel bit per slot, 8 slots per frame) and rebuilds the eight parallel channel outputs. It locks to a frame sync marker, tracks the slot index, and commits each complete frame to registered outputs i0..i7 atomically. It sits at the far end of the serial link, opposite the transmit-side 8:1 mux.

## Interface
Parameters:
- none. Frame length is fixed at 8 data slots, plus 1 parity slot when `TDM_DEMUX8_PARITY_EN` is defined.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  slot strobe; din/sync are sampled only on edges where en=1
- din  input  1  serial channel bit for the current slot
- sync  input  1  frame marker; high together with the slot-0 bit
- i0..i7  output  1 each  registered channel outputs from the last good frame
- s  output  4  slot index expected for the next accepted bit (0..7, or 0..8 with parity)
- locked  output  1  high in state LOCK
- frame_valid  output  1  one-cycle pulse when i0..i7 update
- sync_err  output  1  one-cycle pulse on misplaced sync
- par_err  output  1  one-cycle pulse on parity mismatch (tied 0 when parity is compiled out)

## Operation
- Reset (rst_n=0, asynchronous): state HUNT, s=0, i0..i7=0, shadow register=0, and locked, frame_valid, sync_err, par_err all 0.
- Edges with en=0: no state change. Pulse outputs drop to 0.
- **HUNT**:
  - en=1, sync=0: bit is discarded.
  - en=1, sync=1: din goes into shadow[0], s becomes 1, and the state moves to LOCK.
- **LOCK**, on each en=1 edge:
  - din goes into shadow[s] and s increments.
  - Sync is flywheeled: sync=0 at slot 0 is legal and the block stays locked.
  - Misplaced sync (sync=1 with s≠0): sync_err pulses. The partial frame is discarded, din goes into shadow[0], and s becomes 1. The state stays LOCK.
  - Last slot (s=7, no parity): shadow[7]=din. i0..i7 load shadow[0..6] and din, and frame_valid pulses. s wraps to 0.
  - Parity build, s=7: capture only.
  - Parity build, s=8: if din equals the XOR of shadow[0..7] (even parity over 9 bits), outputs load and frame_valid pulses. Otherwise par_err pulses and the outputs hold. In both cases s wraps to 0.
- Lock loss: a second sync_err within the same frame is impossible by construction. The block never returns to HUNT except through reset.
- Simultaneous events: sync=1 at s=last is a misplaced sync. Resync wins, no commit occurs, and only sync_err pulses.
- Outputs i0..i7 change only on a commit edge, never partially.

## Timing
- All outputs are registered. Pulses are high for exactly the one cycle following the causing edge.
- Latency from the last-slot edge to i0..i7/frame_valid: 1 edge, meaning the values are visible right after that edge.
- A minimum frame takes 8 en-edges (9 with parity). en may be deasserted at any point mid-frame without loss.
- rst_n asserted mid-frame: immediate clear, partial frame lost. After deassertion, the first accepted bit requires sync.

## Configuration
- `TDM_DEMUX8_PARITY_EN` defined:
  - Frames are 9 slots and s counts 0..8.
  - Slot 8 carries even parity.
  - Bad frames are dropped with a par_err pulse.
- Not defined:
  - Frames are 8 slots and s counts 0..7.
  - par_err is constant 0.
  - The parity logic is absent.

## Test plan
- Reset then lock:
  - Stimulus: rst_n low, then high. en=1, sync=1 on the first bit, serial bits 1,1,1,1,0,0,0,0.
  - Response: after the 8th edge, i0..i3=1, i4..i7=0, frame_valid=1 for one cycle, s=0, locked=1.
- Flywheel:
  - Stimulus: the next frame uses bits 1,0,1,0,0,0,0,1 with sync=0 throughout.
  - Response: i0=1, i2=1, i7=1, all others 0, and frame_valid pulses.
- Misplaced sync:
  - Stimulus: sync=1 at s=5.
  - Response: sync_err pulses, s=1, i0..i7 unchanged. The next 7 bits complete a frame and commit.
- en gaps:
  - Stimulus: the frame from the first scenario with en=0 for 3 cycles between slots 3 and 4.
  - Response: identical outputs, frame_valid delayed 3 cycles.
- Reset mid-frame:
  - Stimulus: assert rst_n at s=4.
  - Response: all outputs are 0 immediately and locked=0. Bits without sync are then ignored (s stays 0).
- Parity (macro defined):
  - Stimulus: frame 1,1,1,1,0,0,0,0 with parity bit 1.
  - Response: par_err pulses and the outputs hold. Repeating the frame with parity bit 0 commits it and frame_valid pulses.
